watchdog_multi: RTL
===================

Name: watchdog_multi

Overview:
- Multi-channel, parametrised watchdog/timer block for the SPI master subsystem.
- Provides CH independent down-counters driven by one shared programmable prescaler.
- Each channel has a per-channel mode (off / periodic / one-shot), a software kick (refresh), a one-cycle expiry pulse and a sticky flag with clear.
- A combined interrupt line drives the controller.

Parameters:
- N, 20, counter/reload width per channel
- CH, 4, number of channels (1..16)
- PRE_W, 8, prescaler width

Ports:
- i_clk_p  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_cfg_we  input  1  write channel config (cycles + mode) to channel i_cfg_ch
- i_cfg_ch  input  $clog2(CH) (min 1)  target channel of config write
- i_cycles  input  N  reload value for config write
- i_mode  input  2  mode for config write (wd_mode_e)
- i_pre_we  input  1  write prescaler value
- i_prescale  input  PRE_W  prescaler value P; tick every P+1 clocks
- i_kick  input  CH  per-channel refresh: reload counter from stored cycles
- i_clr  input  CH  per-channel clear of sticky flag
- o_inter  output  CH  registered one-cycle expiry pulse per channel
- o_flag  output  CH  sticky expiry flag per channel
- o_active  output  CH  channel enabled (mode != OFF and cycles != 0)
- o_irq  output  1  registered OR of o_flag

Behaviour:
- Reset (async, i_rst_n=0):
  - All counters, reload registers, prescaler value/count cleared.
  - All modes = WD_OFF.
  - o_inter, o_flag, o_active, o_irq = 0 immediately.
- Prescaler:
  - Register pre_cnt counts down from P; tick = (pre_cnt==0).
  - On tick, pre_cnt reloads to P. P=0 gives a tick every clock.
  - i_pre_we loads P and sets pre_cnt=i_prescale (phase restart); no tick in that cycle.
- Channel state: cycles[N], count[N], mode.
  - Active when mode in {PERIODIC, ONESHOT} and cycles != 0.
  - Mode 2'b11 is reserved and behaves as OFF.
- Per-channel update priority, evaluated per clock:
  1. cfg write to this channel: cycles=count=i_cycles, mode=i_mode.
  2. i_kick[c] while active: count=cycles.
  3. tick while active:
     - count>0: count-1.
     - count==0: expiry.
  4. Otherwise hold.
- Expiry:
  - o_inter[c] is high for exactly one clock, in the clock after the expiring edge.
  - o_flag[c] set.
  - PERIODIC: count reloads to cycles.
  - ONESHOT: mode becomes OFF, count stays 0.
- Period: PERIODIC period = (cycles+1)*(P+1) clocks, absent kicks and writes.
- Inactive channels:
  - Kicks are ignored.
  - Ticks do not decrement.
  - Never expire; cycles==0 means disabled regardless of mode.
- Flag:
  - i_clr[c] clears o_flag[c].
  - Expiry in the same cycle as clear: flag is set (set wins).
- o_irq: registered, = |o_flag, so one clock behind o_flag.
- Simultaneous events:
  - Cfg write and kick to the same channel: cfg wins.
  - Cfg write on an edge where count==0 and tick: no expiry (cfg wins).
  - Kick on an expiry edge: no expiry, counter reloads.
- Config writes touch only the addressed channel. i_cfg_ch >= CH: write ignored.
- Width rules:
  - All counter arithmetic unsigned, N bits.
  - No wrap: count never decrements below 0.

Decomposition:
- Package watchdog_pkg:
  - typedef enum logic [1:0] wd_mode_e {WD_OFF=0, WD_PERIODIC=1, WD_ONESHOT=2, WD_RSVD=3}.
  - Function wd_is_active(mode, cycles).
- Sub-module watchdog_channel (params N): one counter/mode/flag slice.
  - Inputs: tick, cfg_we, cycles, mode, kick, clr.
  - Outputs: inter, flag, active.
- Top instantiates CH copies via generate, plus inline prescaler and irq register.

Test Plan (CH=4, N=20, PRE_W=8):
1. Assert i_rst_n=0 mid-count with ch0 at count 5 -> all outputs 0 asynchronously. After release, no o_inter for 100 clocks.
2. P=0; cfg ch0 PERIODIC cycles=3 at edge k -> o_inter[0] high in clocks k+5, k+9, k+13 (period 4). o_flag[0]=1 from k+5; o_irq=1 from k+6.
3. P=1 (pre_we at edge j); cfg ch1 ONESHOT cycles=2 at edge j -> exactly one o_inter[1] pulse 6±1 clocks later. o_active[1] then 0; no further pulse in 200 clocks. o_flag[1] holds until i_clr[1] -> 0 next clock.
4. P=0; ch2 PERIODIC cycles=3, i_kick[2] every 3 clocks for 60 clocks -> o_inter[2] never asserts. Kicks stop -> pulse 4 clocks after last kick edge.
5. Same-cycle i_clr[3] with ch3 expiry -> o_flag[3] stays 1. Same-cycle cfg_we(ch3, cycles=10) and i_kick[3] -> count=10, period becomes 11.
6. ch0 PERIODIC cycles=0, and ch1 mode=2'b11 cycles=5 -> o_active=0 for both; no o_inter[1:0] over 100 clocks. i_cfg_ch=3 write leaves ch0..2 unchanged.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared types and helpers for the multi-channel watchdog.
// Mode encoding is software-visible; the reserved code behaves as off.
package watchdog_pkg;

    typedef enum logic [1:0] {
        WD_OFF      = 2'd0,
        WD_PERIODIC = 2'd1,
        WD_ONESHOT  = 2'd2,
        WD_RSVD     = 2'd3
    } wd_mode_e;

    // Widest reload supported by wd_is_active; callers size-cast into it.
    localparam int WD_MAX_N = 64;

    function automatic logic wd_is_active(input wd_mode_e mode,
                                          input logic [WD_MAX_N-1:0] cycles);
        return ((mode == WD_PERIODIC) || (mode == WD_ONESHOT)) && (cycles != '0);
    endfunction

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog slice: reload/count/mode registers, expiry pulse and sticky flag.
// Priority per clock is config write, then kick, then prescaler tick.
module watchdog_channel
    import watchdog_pkg::*;
#(
    parameter int N = 20
) (
    input  logic         i_clk_p,
    input  logic         i_rst_n,
    input  logic         tick,
    input  logic         cfg_we,
    input  logic [N-1:0] cycles,
    input  wd_mode_e     mode,
    input  logic         kick,
    input  logic         clr,
    output logic         inter,
    output logic         flag,
    output logic         active
);

    logic [N-1:0] reload_q;
    logic [N-1:0] count_q;
    wd_mode_e     mode_q;
    logic         expire;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        active = wd_is_active(mode_q, WD_MAX_N'(reload_q));
        expire = !cfg_we && !(kick && active) && tick && active && (count_q == '0);
    end

    // NOTE: state uses non-blocking assignments so all slices update from the same pre-edge values.
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reload_q <= '0;
            count_q  <= '0;
            mode_q   <= WD_OFF;
            inter    <= 1'b0;
            flag     <= 1'b0;
        end else begin
            inter <= expire;

            // Set wins over a clear arriving on the same edge.
            if (expire)
                flag <= 1'b1;
            else if (clr)
                flag <= 1'b0;

            if (cfg_we) begin
                reload_q <= cycles;
                count_q  <= cycles;
                mode_q   <= mode;
            end else if (kick && active) begin
                count_q <= reload_q;
            end else if (tick && active) begin
                if (count_q != '0)
                    count_q <= count_q - N'(1);
                else if (mode_q == WD_ONESHOT)
                    mode_q <= WD_OFF;
                else
                    count_q <= reload_q;
            end
        end
    end

endmodule

// File: rtl/watchdog_multi.sv
// CH independent watchdog channels sharing one programmable prescaler,
// with a registered OR of all sticky flags as the interrupt line.
module watchdog_multi
    import watchdog_pkg::*;
#(
    parameter  int N     = 20,
    parameter  int CH    = 4,
    parameter  int PRE_W = 8,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             i_clk_p,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [N-1:0]     i_cycles,
    input  logic [1:0]       i_mode,
    input  logic             i_pre_we,
    input  logic [PRE_W-1:0] i_prescale,
    input  logic [CH-1:0]    i_kick,
    input  logic [CH-1:0]    i_clr,
    output logic [CH-1:0]    o_inter,
    output logic [CH-1:0]    o_flag,
    output logic [CH-1:0]    o_active,
    output logic             o_irq
);

    logic [PRE_W-1:0] pre_val;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    // A prescaler write restarts the phase, so it suppresses the tick on that edge.
    assign tick = (pre_cnt == '0) && !i_pre_we;

    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_val <= '0;
            pre_cnt <= '0;
        end else if (i_pre_we) begin
            pre_val <= i_prescale;
            pre_cnt <= i_prescale;
        end else if (pre_cnt == '0) begin
            pre_cnt <= pre_val;
        end else begin
            pre_cnt <= pre_cnt - PRE_W'(1);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        watchdog_channel #(.N(N)) u_ch (
            .i_clk_p (i_clk_p),
            .i_rst_n (i_rst_n),
            .tick    (tick),
            .cfg_we  (i_cfg_we && (i_cfg_ch == CH_W'(c))),
            .cycles  (i_cycles),
            .mode    (wd_mode_e'(i_mode)),
            .kick    (i_kick[c]),
            .clr     (i_clr[c]),
            .inter   (o_inter[c]),
            .flag    (o_flag[c]),
            .active  (o_active[c])
        );
    end

    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n)
            o_irq <= 1'b0;
        else
            o_irq <= |o_flag;
    end

endmodule
